branch_hazard_ctrl: RTL and testbench

- Sequences the ID-stage branch resolution datapath (operand forwarding muxes, comparator, branch-address adder).
- Drives the two forwarding selects for the branch operands.
- Detects data hazards that the forwarding paths cannot cover, and stalls the front end through a small countdown FSM.
- Flushes IF/ID on a resolved taken branch, and keeps saturating performance counters for branches, taken branches and stall cycles.

---
 rtl/branch_hazard_ctrl.sv | 78 +++++++
 tb/tb_branch_hazard_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch forwarding selects, hazard stall FSM, flush and perf counters
module branch_hazard_ctrl #(
  parameter logic [6:0] BRANCH_OPCODE = 7'b1100011,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             branch_flag,
  output logic [1:0]       select1,
  output logic [1:0]       select2,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             branch_taken_out,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state;
  logic [1:0] cnt, n1, n2, need;
  logic is_br, ex1, ex2, m1, m2, w1, w2, stall, resolve;
  assign is_br = id_valid & (id_opcode == BRANCH_OPCODE);
  assign ex1 = ex_regwrite & (ex_rd != 5'd0) & (ex_rd == id_rs1);
  assign ex2 = ex_regwrite & (ex_rd != 5'd0) & (ex_rd == id_rs2);
  assign m1 = mem_regwrite & (mem_rd != 5'd0) & (mem_rd == id_rs1);
  assign m2 = mem_regwrite & (mem_rd != 5'd0) & (mem_rd == id_rs2);
  assign w1 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign w2 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_rs2);
  // A load in EX needs two cycles before its data reaches wbALUMem; ALU ops in EX and loads in MEM need one
  assign n1 = ex1 ? (ex_memread ? 2'd2 : 2'd1) : {1'b0, m1 & mem_memread};
  assign n2 = ex2 ? (ex_memread ? 2'd2 : 2'd1) : {1'b0, m2 & mem_memread};
  assign need = is_br ? ((n1 > n2) ? n1 : n2) : 2'd0;
  assign stall = rst & ((state == STALL) | (need != 2'd0));
  assign resolve = rst & (state == IDLE) & is_br & (need == 2'd0);
  assign select1 = !rst ? 2'b00 : (m1 & ~mem_memread) ? 2'b01 : w1 ? 2'b10 : 2'b00;
  assign select2 = !rst ? 2'b00 : (m2 & ~mem_memread) ? 2'b01 : w2 ? 2'b10 : 2'b00;
  assign pc_stall = stall;
  assign ifid_stall = stall;
  assign idex_bubble = stall;
  assign branch_taken_out = resolve & branch_flag;
  assign ifid_flush = resolve & branch_flag;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      branch_cnt <= '0;
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (need != 2'd0) begin
          cnt <= need - 2'd1;
          state <= (need > 2'd1) ? STALL : IDLE;
        end
      end else begin
        cnt <= cnt - 2'd1;
        state <= (cnt > 2'd1) ? STALL : IDLE;
      end
      if (resolve && branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if (branch_taken_out && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: table-driven per-cycle vectors checked through a scoreboard queue
module tb_branch_hazard_ctrl;
  localparam int BR = 99, AL = 51, W = 4;
  typedef struct {
    int r, v, op, rs1, rs2, exrd, exw, exm, mrd, mw, mm, wrd, ww, bf, s1, s2, st, fl, tk, id;
  } vec_t;
  logic clk = 0, rst = 0, id_valid = 0, ex_regwrite = 0, ex_memread = 0;
  logic mem_regwrite = 0, mem_memread = 0, wb_regwrite = 0, branch_flag = 0;
  logic [6:0] id_opcode = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
  logic [1:0] select1, select2;
  logic pc_stall, ifid_stall, idex_bubble, ifid_flush, branch_taken_out;
  logic [W-1:0] branch_cnt, taken_cnt, stall_cnt;
  int checks = 0, errors = 0, n = 0;
  vec_t q[$];
  vec_t tbl[16];
  vec_t lu;
  always #5 clk = ~clk;
  branch_hazard_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_flag(branch_flag), .select1(select1), .select2(select2),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .branch_taken_out(branch_taken_out),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic apply(vec_t e);
    rst = e.r[0];
    id_valid = e.v[0];
    id_opcode = 7'(e.op);
    id_rs1 = 5'(e.rs1);
    id_rs2 = 5'(e.rs2);
    ex_rd = 5'(e.exrd);
    ex_regwrite = e.exw[0];
    ex_memread = e.exm[0];
    mem_rd = 5'(e.mrd);
    mem_regwrite = e.mw[0];
    mem_memread = e.mm[0];
    wb_rd = 5'(e.wrd);
    wb_regwrite = e.ww[0];
    branch_flag = e.bf[0];
    e.id = n++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : scoreboard
    vec_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk($sformatf("select1[%0d]", e.id), int'(select1), e.s1);
      chk($sformatf("select2[%0d]", e.id), int'(select2), e.s2);
      chk($sformatf("pc_stall[%0d]", e.id), int'(pc_stall), e.st);
      chk($sformatf("ifid_stall[%0d]", e.id), int'(ifid_stall), e.st);
      chk($sformatf("idex_bubble[%0d]", e.id), int'(idex_bubble), e.st);
      chk($sformatf("ifid_flush[%0d]", e.id), int'(ifid_flush), e.fl);
      chk($sformatf("taken[%0d]", e.id), int'(branch_taken_out), e.tk);
    end
  end
  task automatic chk_cnt(string tag, int b, int t, int s);
    chk({tag, "_branch_cnt"}, int'(branch_cnt), b);
    chk({tag, "_taken_cnt"}, int'(taken_cnt), t);
    chk({tag, "_stall_cnt"}, int'(stall_cnt), s);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    //           r v op rs1 rs2 exrd exw exm mrd mw mm wrd ww bf s1 s2 st fl tk id
    tbl[0]  = '{0, 1, BR, 7, 0,  7, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, BR, 7, 0,  7, 1, 1,  0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, BR, 5, 6,  0, 0, 0,  5, 1, 0,  6, 1, 0, 1, 2, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, BR, 7, 0,  7, 1, 1,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, 1, BR, 7, 0,  0, 0, 0,  7, 1, 1,  0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, BR, 7, 0,  0, 0, 0,  0, 0, 0,  7, 1, 0, 2, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, BR, 1, 3,  3, 1, 0,  0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 1, BR, 1, 3,  0, 0, 0,  3, 1, 0,  0, 0, 1, 0, 1, 0, 1, 1, 0};
    tbl[8]  = '{1, 1, AL, 3, 3,  0, 0, 0,  0, 0, 0,  3, 1, 1, 2, 2, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, BR, 0, 2,  0, 1, 0,  0, 1, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, BR, 7, 0,  7, 1, 1,  0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1, BR, 4, 4,  0, 0, 0,  4, 1, 0,  4, 1, 1, 1, 1, 0, 1, 1, 0};
    tbl[12] = '{1, 1, BR, 8, 9,  9, 1, 1,  8, 1, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[13] = '{1, 1, BR, 8, 9,  0, 0, 0,  9, 1, 1,  8, 1, 0, 2, 0, 1, 0, 0, 0};
    tbl[14] = '{1, 1, BR, 8, 9,  0, 0, 0,  0, 0, 0,  9, 1, 0, 0, 2, 0, 0, 0, 0};
    tbl[15] = '{1, 1, BR, 10, 0, 10, 0, 1, 10, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);
    chk_cnt("table", 7, 2, 5);
    // Reset in the middle of a load-use stall, then a clean branch must resolve at once
    apply(tbl[3]);
    apply('{0, 1, BR, 7, 0, 0, 0, 0, 7, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0});
    chk_cnt("reset", 0, 0, 0);
    apply('{1, 1, BR, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0});
    apply(tbl[3]);
    apply(tbl[4]);
    apply(tbl[5]);
    chk_cnt("after_reset", 2, 1, 2);
    // A load that never retires keeps the front end stalled until stall_cnt saturates
    lu = tbl[3];
    lu.bf = 0;
    repeat (20) apply(lu);
    chk_cnt("saturate", 2, 1, 15);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
